muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer in the execute stage, beside the ALU. When the ALU decode flags an M-extension op, the block takes the operands, freezes the pipeline with stall, and runs a 32-step shift-add or shift-subtract loop. It then presents the result with a one-cycle done pulse. One operation is in flight at a time.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled only in IDLE
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  in  XLEN  operand A (dividend/multiplicand)
rs2  in  XLEN  operand B (divisor/multiplier)
flush  in  1  abort the current operation (branch mispredict/trap)
busy  out  1  state != IDLE
stall  out  1  hold IF/ID/EX registers
done  out  1  one-cycle pulse, result valid
result  out  XLEN  final result; holds until the next accepted start

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, stall=0, done=0, result=0; all internal registers 0.
- States: IDLE, PREP, MUL, DIV, FIX, DONE.
- IDLE: on start=1 and flush=0 at edge N:
  - latch funct3, rs1, rs2 and the signedness of each operand;
  - move to PREP.
- PREP (cycle N+1):
  - Take absolute values of the signed operands.
  - Record the result-negate flag: MUL*/DIV use sign(A) xor sign(B); REM uses sign(A).
  - Clear the 64-bit accumulator and the 5-bit counter.
  - Special cases go straight to DONE with the result preloaded:
    - div-by-zero (rs2==0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
    - signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Otherwise go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- MUL/DIV: one step per cycle for exactly 32 cycles (counter 0..31), then FIX.
  - MUL step: conditional add of the multiplicand, then shift the 64-bit product right.
  - DIV step: shift the remainder:quotient pair left, trial subtract, set the quotient bit if non-negative.
- FIX (one cycle):
  - Two's-complement the 64-bit product, or the quotient/remainder, when the negate flag is set.
  - Select the low word (MUL) or high word (MULH*), quotient or remainder; write result.
- DONE: done=1 for one cycle, then IDLE. A start seen in DONE is ignored; the pipeline reissues it.
- Latency from the start edge N:
  - normal op: done high in cycle N+35;
  - special case: done high in cycle N+2.
- stall = (IDLE & start) | (state in PREP, MUL, DIV, FIX). This is combinational so the issuing instruction holds in the same cycle. stall=0 in DONE, so the pipeline advances while done=1.
- start while busy and not DONE: ignored, no effect.
- flush:
  - synchronous, highest priority after rst; from any state, next state is IDLE;
  - no done pulse; result keeps its previous value;
  - flush with start in IDLE: the start is not accepted.
- rst mid-operation: immediate return to reset values; no done pulse.
- MULHSU: rs1 signed, rs2 unsigned. MULHU/DIVU/REMU: both operands unsigned.

Decomposition:
- Shared package muldiv_pkg:
  - funct3 localparams (MUL..REMU);
  - state encoding (3-bit);
  - constants DIV0_Q=32'hFFFFFFFF and INT_MIN=32'h80000000.
- One natural sub-module, muldiv_step: combinational single iteration.
  - Inputs: mode, accumulator hi/lo, operand.
  - Outputs: next accumulator hi/lo.
- muldiv_seq itself keeps the FSM, counter, sign handling and the final fix-up.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), start at cycle 0 -> stall high for cycles 0-34, done at cycle 35, result=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> result=0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> result=0xFFFFFFFF.
- DIV -7 / 2 -> result 0xFFFFFFFD. REM -7 % 2 -> result 0xFFFFFFFF. DIVU 100 / 7 -> result 14. REMU 100 % 7 -> result 2.
- DIVU 5 / 0 -> done at cycle 2, result=0xFFFFFFFF. REM 5 % 0 -> result=5. DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000, done at cycle 2.
- Start MUL, assert flush at cycle 10 -> busy=0 and stall=0 from cycle 11, no done pulse, result unchanged. A new DIVU 9/3 at cycle 12 -> done at cycle 47, result=3.
- Assert rst asynchronously mid-DIV -> all outputs 0 immediately. A start while in DIV -> ignored: no second done, first result correct.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// funct3 codes, FSM state encoding and the architectural special-case constants.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_MUL  = 3'd2,
        S_DIV  = 3'd3,
        S_FIX  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

    // Magnitude of a value that is only treated as signed when sgn is set.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
        logic signed [XLEN-1:0] s;
        s = v;
        return (sgn && s < 0) ? XLEN'(-s) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the execute stage and the multiply/divide sequencer.
interface muldiv_if;
    import muldiv_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1, rs2, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, funct3, rs1, rs2, flush,
        output busy, stall, done, result
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the unsigned shift-add multiply or
// restoring shift-subtract divide on a {hi, lo} accumulator pair.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            mode,
    input  logic [XLEN-1:0] acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] nxt_hi,
    output logic [XLEN-1:0] nxt_lo
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem;
    logic [XLEN:0] diff;

    // mode 0: lo holds the remaining multiplier bits, hi the partial product.
    // mode 1: lo holds dividend bits becoming quotient, hi the partial remainder.
    always_comb begin
        sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        rem  = {acc_hi, acc_lo[XLEN-1]};
        diff = rem - {1'b0, operand};
        if (!mode) begin
            nxt_hi = sum[XLEN:1];
            nxt_lo = {sum[0], acc_lo[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            nxt_hi = diff[XLEN-1:0];
            nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
        end else begin
            nxt_hi = rem[XLEN-1:0];
            nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: sign-magnitude operands, a
// 32-step unsigned core loop, then a sign fix-up and word select.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DATA_W = XLEN
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);

    state_t          state;
    state_t          state_nxt;

    logic [2:0]      f3_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            a_sgn_q;
    logic            b_sgn_q;
    logic            neg_q;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd;
    logic [4:0]      cnt;
    logic [XLEN-1:0] result_q;

    logic [XLEN-1:0] step_hi;
    logic [XLEN-1:0] step_lo;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            neg_c;
    logic            is_div;
    logic            is_rem;
    logic            div0;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_val;
    logic [XLEN-1:0] fix_val;
    logic signed [2*XLEN-1:0] prod_s;
    logic signed [2*XLEN-1:0] prod_fix;
    logic            busy_c;
    logic            stall_c;
    logic            done_c;

    logic unused_ok;
    assign unused_ok = (DATA_W == XLEN);

    muldiv_step u_step (
        .mode    (state == S_DIV),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (opnd),
        .nxt_hi  (step_hi),
        .nxt_lo  (step_lo)
    );

    // Operand preparation and special-case detection, valid while in PREP.
    always_comb begin
        is_div  = f3_q[2];
        is_rem  = f3_q[2] & f3_q[1];
        abs_a   = abs_val(a_q, a_sgn_q);
        abs_b   = abs_val(b_q, b_sgn_q);
        neg_c   = is_rem ? (a_sgn_q & a_q[XLEN-1])
                         : ((a_sgn_q & a_q[XLEN-1]) ^ (b_sgn_q & b_q[XLEN-1]));
        div0    = is_div && (b_q == '0);
        ovf     = is_div && !f3_q[0] && (a_q == INT_MIN) && (b_q == '1);
        special = div0 | ovf;
        if (div0) begin
            special_val = is_rem ? a_q : DIV0_Q;
        end else begin
            special_val = is_rem ? '0 : INT_MIN;
        end
    end

    // Sign fix-up and result word select, valid while in FIX.
    always_comb begin
        prod_s   = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod_s : prod_s;
        if (!f3_q[2]) begin
            fix_val = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (f3_q[1]) begin
            fix_val = neg_q ? (~acc_hi + 1'b1) : acc_hi;
        end else begin
            fix_val = neg_q ? (~acc_lo + 1'b1) : acc_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        stall_c   = 1'b0;
        done_c    = 1'b0;
        unique case (state)
            S_IDLE: begin
                stall_c = bus.start;
                if (bus.start) state_nxt = S_PREP;
            end
            S_PREP: begin
                busy_c    = 1'b1;
                stall_c   = 1'b1;
                state_nxt = special ? S_DONE : (f3_q[2] ? S_DIV : S_MUL);
            end
            S_MUL, S_DIV: begin
                busy_c  = 1'b1;
                stall_c = 1'b1;
                if (cnt == 5'd31) state_nxt = S_FIX;
            end
            S_FIX: begin
                busy_c    = 1'b1;
                stall_c   = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (bus.flush) state_nxt = S_IDLE;
    end

    // Datapath registers; a flush freezes them so result keeps its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a_sgn_q  <= 1'b0;
            b_sgn_q  <= 1'b0;
            neg_q    <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else if (!bus.flush) begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        f3_q    <= bus.funct3;
                        a_q     <= bus.rs1;
                        b_q     <= bus.rs2;
                        a_sgn_q <= (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) ||
                                   (bus.funct3 == F3_MULHSU) || (bus.funct3 == F3_DIV) ||
                                   (bus.funct3 == F3_REM);
                        b_sgn_q <= (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) ||
                                   (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
                    end
                end
                S_PREP: begin
                    cnt    <= '0;
                    neg_q  <= neg_c;
                    acc_hi <= '0;
                    acc_lo <= f3_q[2] ? abs_a : abs_b;
                    opnd   <= f3_q[2] ? abs_b : abs_a;
                    if (special) result_q <= special_val;
                end
                S_MUL, S_DIV: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 5'd1;
                end
                S_FIX: result_q <= fix_val;
                default: ;
            endcase
        end
    end

    assign bus.busy   = busy_c;
    assign bus.stall  = stall_c;
    assign bus.done   = done_c;
    assign bus.result = result_q;

endmodule
